// File: rtl/contr_updown_pkg.sv
// Shared definitions for the up/down counter family: width, direction
// encoding, count type and a reusable single-step function.
package contr_updown_pkg;

  localparam int CNT_WIDTH = 4;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  // One step up or down, wrapping modulo 2^CNT_WIDTH (carry/borrow dropped).
  function automatic cnt_t next_cnt(cnt_t c, logic up);
    if (up == DIR_UP) begin
      next_cnt = c + cnt_t'(1);
    end else begin
      next_cnt = c - cnt_t'(1);
    end
  endfunction

endpackage : contr_updown_pkg

// File: rtl/contr_updown_4.sv
// Free-running synchronous up/down counter with wrap-around.
// The output comes straight from the count register, so there is no
// combinational path from s or rst to y.
module contr_updown_4
  import contr_updown_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] cnt;

  // Count register: synchronous active-low clear, otherwise step by one in the direction chosen by s.
  always_ff @(posedge clk) begin
    // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      cnt <= '0;
    end else if (s == DIR_UP) begin
      cnt <= cnt + WIDTH'(1);
    end else begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign y = cnt;

endmodule : contr_updown_4

// File: tb/tb_contr_updown_4.sv
// Self-checking bench for contr_updown_4: directed scenarios followed by
// randomized stimulus, all compared against an arithmetic reference model.
module tb_contr_updown_4;

  localparam int MOD = 16;

  logic       clk;
  logic       rst;
  logic       s;
  logic [3:0] y;

  int         checks;
  int         failures;
  int         model_cnt;   // reference count, plain integer arithmetic
  logic [3:0] exp_y;

  contr_updown_4 #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .s   (s),
    .y   (y)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Reference behaviour: reset clears, otherwise +1 or -1 modulo 16.
  function automatic int model_next(int c, logic r, logic up);
    if (r == 1'b0) return 0;
    if (up == 1'b1) return (c + 1) % MOD;
    return (c + MOD - 1) % MOD;
  endfunction

  // Apply inputs, take one rising edge, sample 1 ns later, advance the model.
  task automatic drive_edge(input logic r, input logic dir);
    rst = r;
    s   = dir;
    @(posedge clk);
    #1;
    model_cnt = model_next(model_cnt, r, dir);
    exp_y     = 4'(model_cnt);
  endtask

  task automatic test_reset();
    drive_edge(1'b0, 1'b0);
    checks++;
    if (y !== 4'd0) begin
      failures++;
      $display("FAIL reset_first_edge: y=%0d expected=0", y);
    end
    for (int i = 0; i < 2; i++) begin
      drive_edge(1'b0, 1'b1);
      checks++;
      if (y !== 4'd0) begin
        failures++;
        $display("FAIL reset_hold[%0d]: y=%0d expected=0", i, y);
      end
    end
  endtask

  task automatic test_count_up();
    for (int i = 1; i <= 4; i++) begin
      drive_edge(1'b1, 1'b1);
      checks++;
      if (y !== exp_y || y !== 4'(i)) begin
        failures++;
        $display("FAIL count_up[%0d]: y=%0d expected=%0d", i, y, i);
      end
    end
  endtask

  task automatic test_count_down();
    for (int i = 3; i >= 0; i--) begin
      drive_edge(1'b1, 1'b0);
      checks++;
      if (y !== exp_y || y !== 4'(i)) begin
        failures++;
        $display("FAIL count_down[%0d]: y=%0d expected=%0d", i, y, i);
      end
    end
  endtask

  task automatic test_wrap();
    drive_edge(1'b1, 1'b0);
    checks++;
    if (y !== 4'd15) begin
      failures++;
      $display("FAIL wrap_down: y=%0d expected=15", y);
    end
    drive_edge(1'b1, 1'b1);
    checks++;
    if (y !== 4'd0) begin
      failures++;
      $display("FAIL wrap_up: y=%0d expected=0", y);
    end
    for (int i = 1; i <= 16; i++) begin
      drive_edge(1'b1, 1'b1);
      checks++;
      if (y !== exp_y || y !== 4'(i % MOD)) begin
        failures++;
        $display("FAIL up_sweep[%0d]: y=%0d expected=%0d", i, y, i % MOD);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    for (int i = 0; i < 9; i++) drive_edge(1'b1, 1'b1);
    checks++;
    if (y !== 4'd9) begin
      failures++;
      $display("FAIL mid_reset_setup: y=%0d expected=9", y);
    end
    // Drop rst roughly halfway between edges; y must hold until the edge.
    #48;
    rst = 1'b0;
    s   = $urandom_range(0, 1);
    #1;
    checks++;
    if (y !== 4'd9) begin
      failures++;
      $display("FAIL mid_reset_async: y=%0d expected=9", y);
    end
    @(posedge clk);
    #1;
    model_cnt = 0;
    checks++;
    if (y !== 4'd0) begin
      failures++;
      $display("FAIL mid_reset_edge: y=%0d expected=0", y);
    end
    drive_edge(1'b1, 1'b1);
    checks++;
    if (y !== 4'd1) begin
      failures++;
      $display("FAIL mid_reset_resume: y=%0d expected=1", y);
    end
  endtask

  task automatic test_toggle();
    logic [3:0] want [4];
    want[0] = 4'd6; want[1] = 4'd5; want[2] = 4'd6; want[3] = 4'd5;
    // Reach 5 from 1.
    for (int i = 0; i < 4; i++) drive_edge(1'b1, 1'b1);
    checks++;
    if (y !== 4'd5) begin
      failures++;
      $display("FAIL toggle_setup: y=%0d expected=5", y);
    end
    for (int i = 0; i < 4; i++) begin
      drive_edge(1'b1, (i % 2 == 0) ? 1'b1 : 1'b0);
      checks++;
      if (y !== want[i] || y !== exp_y) begin
        failures++;
        $display("FAIL toggle[%0d]: y=%0d expected=%0d", i, y, want[i]);
      end
    end
  endtask

  task automatic test_random();
    logic r;
    logic d;
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 15) != 0);
      d = $urandom_range(0, 1);
      drive_edge(r, d);
      checks++;
      if (y !== exp_y) begin
        failures++;
        $display("FAIL random[%0d]: rst=%0b s=%0b y=%0d expected=%0d", i, r, d, y, exp_y);
      end
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    model_cnt = 0;
    exp_y     = '0;
    rst       = 1'b0;
    s         = 1'b0;
    #1;
    test_reset();
    test_count_up();
    test_count_down();
    test_wrap();
    test_reset_mid_count();
    test_toggle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_contr_updown_4
